// File: rtl/systolic_array_param.sv
// Output-stationary NxN systolic matrix multiplier: streams A columns and B rows in,
// skews them internally, drains the wavefront, then emits C one row per cycle.
module systolic_array_param #(
  parameter  int N      = 4,
  parameter  int DW     = 8,
  parameter  int SIGNED = 0,
  localparam int AW     = 2*DW + $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  output logic            in_ready,
  input  logic [N*DW-1:0] matrix_a_in,
  input  logic [N*DW-1:0] matrix_b_in,
  output logic            valid_out,
  output logic [N*AW-1:0] matrix_c_out,
  output logic            last_out
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST_IDX   = CW'(N-1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2*N-3);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          advance;
  logic          drain;
  logic          clear;

  logic [DW-1:0] a_feed [N];
  logic [DW-1:0] b_feed [N];
  logic [DW-1:0] a_edge [N];
  logic [DW-1:0] b_edge [N];
  logic [DW-1:0] a_pass [N][N-1];
  logic [DW-1:0] b_pass [N-1][N];
  logic [AW-1:0] acc_arr [N][N];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt counts accepted beats in LOAD, drain cycles in DRAIN and the row index in OUT
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    advance    = 1'b0;
    drain      = 1'b0;
    clear      = 1'b0;
    valid_out  = 1'b0;
    last_out   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (valid_in) begin
          advance    = 1'b1;
          state_next = LOAD;
          cnt_next   = CW'(1);
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (valid_in) begin
          advance = 1'b1;
          if (cnt == LAST_IDX) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      DRAIN: begin
        advance = 1'b1;
        drain   = 1'b1;
        if (cnt == DRAIN_LAST) begin
          state_next = OUT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      OUT: begin
        valid_out = 1'b1;
        if (cnt == LAST_IDX) begin
          last_out   = 1'b1;
          clear      = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A row i and B column j pass through i (resp. j) skew stages before entering the grid
  for (genvar i = 0; i < N; i++) begin : g_skew
    assign a_feed[i] = drain ? '0 : matrix_a_in[i*DW +: DW];
    assign b_feed[i] = drain ? '0 : matrix_b_in[i*DW +: DW];
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_feed[i];
      assign b_edge[i] = b_feed[i];
    end else begin : g_delay
      logic [DW-1:0] a_sr [i];
      logic [DW-1:0] b_sr [i];
      always_ff @(posedge clk) begin
        if (!reset || clear) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else if (advance) begin
          a_sr[0] <= a_feed[i];
          b_sr[0] <= b_feed[i];
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end
      assign a_edge[i] = a_sr[i-1];
      assign b_edge[i] = b_sr[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [DW-1:0] op_a, op_b;
      logic [AW-1:0] prod;
      logic [AW-1:0] acc_q;

      if (j == 0) begin : g_a_edge
        assign op_a = a_edge[i];
      end else begin : g_a_nbr
        assign op_a = a_pass[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign op_b = b_edge[j];
      end else begin : g_b_nbr
        assign op_b = b_pass[i-1][j];
      end

      if (SIGNED != 0) begin : g_smul
        logic signed [2*DW-1:0] p;
        assign p    = $signed(op_a) * $signed(op_b);
        assign prod = {{(AW-2*DW){p[2*DW-1]}}, p};
      end else begin : g_umul
        logic [2*DW-1:0] p;
        assign p    = op_a * op_b;
        assign prod = {{(AW-2*DW){1'b0}}, p};
      end

      always_ff @(posedge clk) begin
        if (!reset || clear) begin
          acc_q <= '0;
        end else if (advance) begin
          acc_q <= acc_q + prod;
        end
      end
      assign acc_arr[i][j] = acc_q;

      // Operand forwarding registers exist only where a neighbour consumes them
      if (j < N-1) begin : g_a_reg
        logic [DW-1:0] a_q;
        always_ff @(posedge clk) begin
          if (!reset || clear) begin
            a_q <= '0;
          end else if (advance) begin
            a_q <= op_a;
          end
        end
        assign a_pass[i][j] = a_q;
      end
      if (i < N-1) begin : g_b_reg
        logic [DW-1:0] b_q;
        always_ff @(posedge clk) begin
          if (!reset || clear) begin
            b_q <= '0;
          end else if (advance) begin
            b_q <= op_b;
          end
        end
        assign b_pass[i][j] = b_q;
      end
    end
  end

  always_comb begin
    matrix_c_out = '0;
    if (state == OUT) begin
      for (int r = 0; r < N; r++) begin
        if (cnt == CW'(r)) begin
          for (int c = 0; c < N; c++) begin
            matrix_c_out[c*AW +: AW] = acc_arr[r][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_param.sv
// Directed bench for systolic_array_param: N=3 functional/latency/bubble/back-to-back/reset
// jobs, N=2 signed vs unsigned, and N=4 full-scale operands.
module tb_systolic_array_param;

  logic clk = 1'b0;
  logic reset;

  logic        d3_valid, d3_in_ready, d3_vout, d3_last;
  logic [23:0] d3_a, d3_b;
  logic [53:0] d3_c;

  logic        ab2_valid;
  logic [15:0] ab2_a, ab2_b;
  logic        s2_in_ready, s2_vout, s2_last;
  logic [33:0] s2_c;
  logic        u2_in_ready, u2_vout, u2_last;
  logic [33:0] u2_c;

  logic        d4_valid, d4_in_ready, d4_vout, d4_last;
  logic [31:0] d4_a, d4_b;
  logic [71:0] d4_c;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] a1 [3] = '{24'h070401, 24'h080502, 24'h090603};
  logic [23:0] b1 [3] = '{24'h030102, 24'h070504, 24'h080906};
  logic [23:0] a2 [3] = '{24'h000001, 24'h000200, 24'h030000};
  int exp1 [3][3] = '{'{28, 38, 41}, '{64, 83, 95}, '{100, 128, 149}};
  int exp2 [3][3] = '{'{2, 1, 3}, '{8, 10, 14}, '{18, 27, 24}};

  systolic_array_param #(.N(3), .DW(8), .SIGNED(0)) dut3 (
    .clk(clk), .reset(reset), .valid_in(d3_valid), .in_ready(d3_in_ready),
    .matrix_a_in(d3_a), .matrix_b_in(d3_b), .valid_out(d3_vout),
    .matrix_c_out(d3_c), .last_out(d3_last));

  systolic_array_param #(.N(2), .DW(8), .SIGNED(1)) dut2s (
    .clk(clk), .reset(reset), .valid_in(ab2_valid), .in_ready(s2_in_ready),
    .matrix_a_in(ab2_a), .matrix_b_in(ab2_b), .valid_out(s2_vout),
    .matrix_c_out(s2_c), .last_out(s2_last));

  systolic_array_param #(.N(2), .DW(8), .SIGNED(0)) dut2u (
    .clk(clk), .reset(reset), .valid_in(ab2_valid), .in_ready(u2_in_ready),
    .matrix_a_in(ab2_a), .matrix_b_in(ab2_b), .valid_out(u2_vout),
    .matrix_c_out(u2_c), .last_out(u2_last));

  systolic_array_param #(.N(4), .DW(8), .SIGNED(0)) dut4 (
    .clk(clk), .reset(reset), .valid_in(d4_valid), .in_ready(d4_in_ready),
    .matrix_a_in(d4_a), .matrix_b_in(d4_b), .valid_out(d4_vout),
    .matrix_c_out(d4_c), .last_out(d4_last));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    d3_valid = 1'b1; d3_a = 24'hFFFFFF; d3_b = 24'hFFFFFF;
    repeat (2) tick();
    vectors++;
    if (d3_in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL rst_in_ready: got %b, want 1", d3_in_ready);
    end
    vectors++;
    if (d3_vout !== 1'b0 || d3_last !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_valid_last: got %b%b, want 00", d3_vout, d3_last);
    end
    vectors++;
    if (d3_c !== '0) begin
      miscompares++; $display("[TB] FAIL rst_c_out: got %h, want 0", d3_c);
    end
    vectors++;
    if ({s2_in_ready, u2_in_ready, d4_in_ready, s2_vout, u2_vout, d4_vout, s2_last, u2_last, d4_last}
        !== 9'b111_000_000) begin
      miscompares++; $display("[TB] FAIL rst_other_dut: got %b%b%b %b%b%b, want 111 000",
        s2_in_ready, u2_in_ready, d4_in_ready, s2_vout, u2_vout, d4_vout);
    end
    d3_valid = 1'b0; d3_a = '0; d3_b = '0;
    reset = 1'b1;
    tick();
  endtask

  // Drives job 1 with an optional bubble before beat 2, then checks timing and all rows
  task automatic run_job3(input int gap, input string tag);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        for (int g = 0; g < gap; g++) begin
          d3_valid = 1'b0; d3_a = 24'hFFFFFF; d3_b = 24'hFFFFFF;
          tick();
        end
      end
      d3_valid = 1'b1; d3_a = a1[k]; d3_b = b1[k];
      vectors++;
      if (d3_in_ready !== 1'b1) begin
        miscompares++; $display("[TB] FAIL %s ready_beat%0d: got %b, want 1", tag, k, d3_in_ready);
      end
      tick();
    end
    d3_valid = 1'b0; d3_a = '0; d3_b = '0;
    repeat (3) tick();
    vectors++;
    if (d3_vout !== 1'b0 || d3_in_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL %s drain_end: got vout=%b rdy=%b, want 0 0", tag, d3_vout, d3_in_ready);
    end
    for (int r = 0; r < 3; r++) begin
      tick();
      vectors++;
      if (d3_vout !== 1'b1 || d3_last !== (r == 2)) begin
        miscompares++; $display("[TB] FAIL %s row%0d_flags: got vout=%b last=%b, want 1 %b", tag, r, d3_vout, d3_last, r == 2);
      end
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (d3_c[j*18 +: 18] !== 18'(exp1[r][j])) begin
          miscompares++; $display("[TB] FAIL %s c[%0d][%0d]: got %0d, want %0d", tag, r, j, d3_c[j*18 +: 18], exp1[r][j]);
        end
      end
    end
    tick();
    vectors++;
    if (d3_vout !== 1'b0 || d3_c !== '0 || d3_in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL %s after_out: got vout=%b c=%h rdy=%b, want 0 0 1", tag, d3_vout, d3_c, d3_in_ready);
    end
  endtask

  task automatic test_basic();
    run_job3(0, "basic");
  endtask

  task automatic test_bubble();
    run_job3(2, "bubble");
  endtask

  task automatic test_back_to_back();
    int beat = 0, job = 0, rows = 0, busy = 0, n_acc = 0;
    int acc_cyc [6];
    bit acc;
    for (int cyc = 0; cyc < 60 && rows < 6; cyc++) begin
      if (d3_vout === 1'b1) begin
        vectors++;
        if (d3_last !== ((rows % 3) == 2)) begin
          miscompares++; $display("[TB] FAIL b2b last_row%0d: got %b, want %b", rows, d3_last, (rows % 3) == 2);
        end
        for (int j = 0; j < 3; j++) begin
          int want = (rows < 3) ? exp1[rows % 3][j] : exp2[rows % 3][j];
          vectors++;
          if (d3_c[j*18 +: 18] !== 18'(want)) begin
            miscompares++; $display("[TB] FAIL b2b row%0d col%0d: got %0d, want %0d", rows, j, d3_c[j*18 +: 18], want);
          end
        end
        rows++;
      end
      if (d3_in_ready !== 1'b1) busy++;
      d3_valid = 1'b1;
      d3_a = (job == 1) ? a2[beat] : a1[beat];
      d3_b = b1[beat];
      acc = (d3_in_ready === 1'b1) && (job < 2);
      if (acc) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      tick();
      if (acc) begin
        beat++;
        if (beat == 3) begin beat = 0; job++; end
      end
    end
    d3_valid = 1'b0; d3_a = '0; d3_b = '0;
    vectors++;
    if (rows != 6) begin
      miscompares++; $display("[TB] FAIL b2b rows_seen: got %0d, want 6", rows);
    end
    vectors++;
    if (busy != 14) begin
      miscompares++; $display("[TB] FAIL b2b busy_cycles: got %0d, want 14", busy);
    end
    vectors++;
    if (n_acc != 6 || acc_cyc[3] - acc_cyc[2] != 8) begin
      miscompares++; $display("[TB] FAIL b2b job2_accept_gap: got %0d beats gap %0d, want 6 beats gap 8", n_acc, acc_cyc[3] - acc_cyc[2]);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    // Abort during DRAIN
    for (int k = 0; k < 3; k++) begin
      d3_valid = 1'b1; d3_a = a1[k]; d3_b = b1[k];
      tick();
    end
    d3_valid = 1'b0; d3_a = '0; d3_b = '0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++;
    if (d3_in_ready !== 1'b1 || d3_vout !== 1'b0) begin
      miscompares++; $display("[TB] FAIL abort_drain_state: got rdy=%b vout=%b, want 1 0", d3_in_ready, d3_vout);
    end
    seen = 0;
    repeat (10) begin tick(); if (d3_vout !== 1'b0) seen++; end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("[TB] FAIL abort_drain_rows: got %0d valid cycles, want 0", seen);
    end
    // Abort during LOAD after two beats
    for (int k = 0; k < 2; k++) begin
      d3_valid = 1'b1; d3_a = a1[k]; d3_b = b1[k];
      tick();
    end
    d3_valid = 1'b0; d3_a = '0; d3_b = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    seen = 0;
    repeat (10) begin tick(); if (d3_vout !== 1'b0) seen++; end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("[TB] FAIL abort_load_rows: got %0d valid cycles, want 0", seen);
    end
    run_job3(0, "post_rst");
  endtask

  task automatic test_signed_n2();
    for (int k = 0; k < 2; k++) begin
      ab2_valid = 1'b1; ab2_a = 16'hFFFF; ab2_b = 16'h0202;
      tick();
    end
    ab2_valid = 1'b0; ab2_a = '0; ab2_b = '0;
    tick();
    vectors++;
    if (s2_vout !== 1'b0 || u2_vout !== 1'b0) begin
      miscompares++; $display("[TB] FAIL n2_early: got s=%b u=%b, want 0 0", s2_vout, u2_vout);
    end
    for (int r = 0; r < 2; r++) begin
      tick();
      vectors++;
      if (s2_vout !== 1'b1 || u2_vout !== 1'b1 || s2_last !== (r == 1) || u2_last !== (r == 1)) begin
        miscompares++; $display("[TB] FAIL n2_row%0d_flags: got vout=%b%b last=%b%b, want 11 %b", r, s2_vout, u2_vout, s2_last, u2_last, r == 1);
      end
      for (int j = 0; j < 2; j++) begin
        vectors++;
        if (s2_c[j*17 +: 17] !== 17'h1FFFC) begin
          miscompares++; $display("[TB] FAIL n2_signed c[%0d][%0d]: got %h, want 1fffc", r, j, s2_c[j*17 +: 17]);
        end
        vectors++;
        if (u2_c[j*17 +: 17] !== 17'h003FC) begin
          miscompares++; $display("[TB] FAIL n2_unsigned c[%0d][%0d]: got %h, want 003fc", r, j, u2_c[j*17 +: 17]);
        end
      end
    end
    tick();
    vectors++;
    if (s2_vout !== 1'b0 || s2_c !== '0 || u2_c !== '0) begin
      miscompares++; $display("[TB] FAIL n2_after_out: got vout=%b s=%h u=%h, want 0 0 0", s2_vout, s2_c, u2_c);
    end
  endtask

  task automatic test_full_scale_n4();
    for (int k = 0; k < 4; k++) begin
      d4_valid = 1'b1; d4_a = 32'hFFFFFFFF; d4_b = 32'hFFFFFFFF;
      tick();
    end
    d4_valid = 1'b0; d4_a = '0; d4_b = '0;
    repeat (5) tick();
    vectors++;
    if (d4_vout !== 1'b0) begin
      miscompares++; $display("[TB] FAIL n4_early: got %b, want 0", d4_vout);
    end
    for (int r = 0; r < 4; r++) begin
      tick();
      vectors++;
      if (d4_vout !== 1'b1 || d4_last !== (r == 3)) begin
        miscompares++; $display("[TB] FAIL n4_row%0d_flags: got vout=%b last=%b, want 1 %b", r, d4_vout, d4_last, r == 3);
      end
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (d4_c[j*18 +: 18] !== 18'h3F804) begin
          miscompares++; $display("[TB] FAIL n4 c[%0d][%0d]: got %h, want 3f804", r, j, d4_c[j*18 +: 18]);
        end
      end
    end
    tick();
    vectors++;
    if (d4_vout !== 1'b0 || d4_in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL n4_after_out: got vout=%b rdy=%b, want 0 1", d4_vout, d4_in_ready);
    end
  endtask

  initial begin
    reset = 1'b0;
    d3_valid = 1'b0; d3_a = '0; d3_b = '0;
    ab2_valid = 1'b0; ab2_a = '0; ab2_b = '0;
    d4_valid = 1'b0; d4_a = '0; d4_b = '0;
    test_reset();
    test_basic();
    test_bubble();
    test_back_to_back();
    test_reset_abort();
    test_signed_n2();
    test_full_scale_n4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
